// File: rtl/oled_pkg.sv
// Shared geometry, widths and FSM state type for the OLED text feeder.
package oled_pkg;
  localparam int unsigned OLED_COLS  = 16;
  localparam int unsigned OLED_PAGES = 4;
  localparam int unsigned OLED_CHARS = OLED_COLS * OLED_PAGES;
  localparam int unsigned CHAR_W     = 7;
  localparam int unsigned IDX_W      = 6;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OLED_CHARS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESENT,
    ST_RELEASE
  } state_e;
endpackage

// File: rtl/oled_char_buf.sv
// 64-entry ASCII screen buffer: one synchronous write port, one combinational read port.
module oled_char_buf
  import oled_pkg::*;
#(
  parameter logic [CHAR_W-1:0] BLANK_CHAR = 7'h20
) (
  input  logic              i_clk,
  input  logic              i_arst_n,
  input  logic              i_wr_en,
  input  logic [IDX_W-1:0]  i_wr_addr,
  input  logic [CHAR_W-1:0] i_wr_char,
  input  logic [IDX_W-1:0]  i_rd_addr,
  output logic [CHAR_W-1:0] o_rd_char
);
  logic [CHAR_W-1:0] mem_q [OLED_CHARS];

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      for (int unsigned i = 0; i < OLED_CHARS; i++) mem_q[i] <= BLANK_CHAR;
    end else if (i_wr_en) begin
      mem_q[i_wr_addr] <= i_wr_char;
    end
  end

  assign o_rd_char = mem_q[i_rd_addr];
endmodule

// File: rtl/oled_text_feeder.sv
// Streams the 64-char screen buffer to oled_cntrl one character per valid/done handshake.
module oled_text_feeder
  import oled_pkg::*;
#(
  parameter bit                AUTO_REFRESH = 1'b1,
  parameter logic [CHAR_W-1:0] BLANK_CHAR   = 7'h20
) (
  input  logic              i_clk,
  input  logic              i_arst_n,
  input  logic              i_wr_en,
  input  logic [IDX_W-1:0]  i_wr_addr,
  input  logic [CHAR_W-1:0] i_wr_char,
  input  logic              i_refresh,
  output logic [CHAR_W-1:0] o_data,
  output logic              o_data_valid,
  input  logic              i_done,
  output logic              o_busy,
  output logic              o_frame_done
);
  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d, rd_addr;
  logic [CHAR_W-1:0] data_q, data_d, rd_char;
  logic              valid_q, valid_d;
  logic              pending_q, pending_d;
  logic              dirty_q, dirty_d;
  logic              frame_done;

  // Read port looks one entry ahead: entry 0 when starting a frame, idx+1 when advancing.
  assign rd_addr = (state_q == ST_IDLE) ? '0 : idx_q + 1'b1;

  oled_char_buf #(.BLANK_CHAR(BLANK_CHAR)) u_buf (
    .i_clk     (i_clk),
    .i_arst_n  (i_arst_n),
    .i_wr_en   (i_wr_en),
    .i_wr_addr (i_wr_addr),
    .i_wr_char (i_wr_char),
    .i_rd_addr (rd_addr),
    .o_rd_char (rd_char)
  );

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      data_q    <= BLANK_CHAR;
      valid_q   <= 1'b0;
      pending_q <= 1'b1;
      dirty_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      pending_q <= pending_d;
      dirty_q   <= dirty_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    data_d     = data_q;
    valid_d    = valid_q;
    pending_d  = pending_q;
    dirty_d    = dirty_q;
    frame_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pending_q || (AUTO_REFRESH && dirty_q)) begin
          pending_d = 1'b0;
          dirty_d   = 1'b0;
          idx_d     = '0;
          data_d    = rd_char;
          valid_d   = 1'b1;
          state_d   = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        if (i_done) begin
          valid_d = 1'b0;
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (!i_done) begin
          if (idx_q == LAST_IDX) begin
            idx_d      = '0;
            frame_done = 1'b1;
            state_d    = ST_IDLE;
          end else begin
            idx_d   = idx_q + 1'b1;
            data_d  = rd_char;
            valid_d = 1'b1;
            state_d = ST_PRESENT;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Requests landing in the frame-start cycle survive the clear above.
    if (i_refresh) pending_d = 1'b1;
    if (i_wr_en)   dirty_d   = 1'b1;
  end

  assign o_data       = data_q;
  assign o_data_valid = valid_q;
  assign o_busy       = (state_q != ST_IDLE);
  assign o_frame_done = frame_done;
endmodule

// File: tb/tb_oled_text_feeder.sv
// Bench for oled_text_feeder: behavioural controller plus a frame-level screen model.
module tb_oled_text_feeder;
  logic       clk, rst_n;
  logic       wr_en, refresh, done;
  logic [5:0] wr_addr;
  logic [6:0] wr_char;
  logic [6:0] o_data;
  logic       o_data_valid, o_busy, o_frame_done;

  int passed = 0;
  int total  = 0;

  oled_text_feeder #(.AUTO_REFRESH(1'b1), .BLANK_CHAR(7'h20)) u_dut (
    .i_clk        (clk),
    .i_arst_n     (rst_n),
    .i_wr_en      (wr_en),
    .i_wr_addr    (wr_addr),
    .i_wr_char    (wr_char),
    .i_refresh    (refresh),
    .o_data       (o_data),
    .o_data_valid (o_data_valid),
    .i_done       (done),
    .o_busy       (o_busy),
    .o_frame_done (o_frame_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void chk(input bit ok, input string nm, input int act, input int exp);
    total++;
    if (ok) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endfunction

  // Controller model: raise done `dly` cycles after valid is seen, keep it high `hold` cycles.
  int dly = 2, hold = 2, wcnt = 0, hcnt = 0;
  initial begin
    done = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        done = 1'b0; wcnt = 0; hcnt = 0;
      end else if (hcnt > 0) begin
        hcnt--;
        if (hcnt == 0) done = 1'b0;
      end else if (o_data_valid && !done) begin
        if (wcnt >= dly) begin done = 1'b1; hcnt = hold; wcnt = 0; end
        else wcnt++;
      end
    end
  end

  // Screen contents as the host has written them.
  logic [6:0] shadow [64];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) shadow[i] <= 7'h20;
    end else if (wr_en) begin
      shadow[wr_addr] <= wr_char;
    end
  end

  // Each new char must be the screen entry for its position, as it stood one cycle earlier.
  logic [6:0] snap [64];
  logic [6:0] frame_chars [64];
  logic [6:0] held;
  int exp_idx = 0, frames = 0, chars_seen = 0;
  bit prev_valid = 0, prev_done = 0;
  initial begin
    for (int i = 0; i < 64; i++) begin snap[i] = 7'h20; frame_chars[i] = 7'h00; end
    held = 7'h20;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_idx = 0; prev_valid = 0; prev_done = 0;
        for (int i = 0; i < 64; i++) snap[i] = 7'h20;
      end else begin
        if (o_data_valid && !prev_valid) begin
          chk(!prev_done, "gap_done_low", int'(prev_done), 0);
          chk(exp_idx < 64, "char_in_frame", exp_idx, 63);
          chk(o_data == snap[exp_idx % 64], "char_value", int'(o_data), int'(snap[exp_idx % 64]));
          frame_chars[exp_idx % 64] = o_data;
          held = o_data;
          exp_idx++;
          chars_seen++;
        end else if (o_data_valid) begin
          chk(o_data == held, "data_stable", int'(o_data), int'(held));
        end
        if (o_frame_done) begin
          chk(exp_idx == 64, "frame_len", exp_idx, 64);
          frames++;
          exp_idx = 0;
        end
        if (o_data_valid || o_frame_done) chk(o_busy, "busy_in_frame", int'(o_busy), 1);
        prev_valid = o_data_valid;
        prev_done  = done;
        for (int i = 0; i < 64; i++) snap[i] = shadow[i];
      end
    end
  end

  task automatic wait_idle(input int budget);
    int quiet = 0, n = 0;
    while (quiet < 4 && n < budget) begin
      @(negedge clk);
      n++;
      if (!o_busy && !o_data_valid) quiet++; else quiet = 0;
    end
    chk(quiet >= 4, "idle_timeout", n, budget);
  endtask

  task automatic wait_idx(input int target, input int budget);
    int n = 0;
    while (exp_idx != target && n < budget) begin @(negedge clk); n++; end
    chk(exp_idx == target, "idx_timeout", exp_idx, target);
  endtask

  task automatic pulse_refresh();
    refresh = 1'b1; @(negedge clk); refresh = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk(o_data == 7'h20, {tag, "_data"}, int'(o_data), 'h20);
    chk(!o_data_valid, {tag, "_valid"}, int'(o_data_valid), 0);
    chk(!o_busy, {tag, "_busy"}, int'(o_busy), 0);
    chk(!o_frame_done, {tag, "_fdone"}, int'(o_frame_done), 0);
  endtask

  int f0, c0;
  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_char = '0; refresh = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Power-up frame of blanks
    wait_idle(2000);
    chk(frames == 1, "powerup_frames", frames, 1);
    chk(chars_seen == 64, "powerup_chars", chars_seen, 64);
    chk(frame_chars[0] == 7'h20, "powerup_c0", int'(frame_chars[0]), 'h20);
    chk(frame_chars[63] == 7'h20, "powerup_c63", int'(frame_chars[63]), 'h20);

    // Back-to-back writes: the second lands on the frame-start cycle and re-dirties
    f0 = frames;
    wr_en = 1'b1; wr_addr = 6'd5; wr_char = 7'h41;
    @(negedge clk);
    wr_addr = 6'd63; wr_char = 7'h5A; refresh = 1'b1;
    @(negedge clk);
    wr_en = 1'b0; refresh = 1'b0;
    wait_idle(4000);
    chk(frames - f0 == 2, "write_frames", frames - f0, 2);
    chk(frame_chars[5] == 7'h41, "write_c5", int'(frame_chars[5]), 'h41);
    chk(frame_chars[63] == 7'h5A, "write_c63", int'(frame_chars[63]), 'h5A);
    chk(frame_chars[4] == 7'h20, "write_c4", int'(frame_chars[4]), 'h20);

    // Long done delay; overwrite entry 0 while it is being presented
    f0 = frames; dly = 500;
    pulse_refresh();
    wait_idx(1, 50);
    wr_en = 1'b1; wr_addr = 6'd0; wr_char = 7'h42;
    @(negedge clk);
    wr_en = 1'b0;
    repeat (450) @(negedge clk);
    chk(o_data_valid, "slow_valid_held", int'(o_data_valid), 1);
    chk(o_data == 7'h20, "slow_data_held", int'(o_data), 'h20);
    dly = 2;
    wait_idle(4000);
    chk(frames - f0 == 2, "slow_frames", frames - f0, 2);
    chk(frame_chars[0] == 7'h42, "slow_next_c0", int'(frame_chars[0]), 'h42);

    // Refresh requests during a frame coalesce into one follow-up frame
    f0 = frames; c0 = chars_seen;
    pulse_refresh();
    wait_idx(10, 500);
    for (int k = 0; k < 3; k++) begin pulse_refresh(); repeat (5) @(negedge clk); end
    wait_idle(4000);
    chk(frames - f0 == 2, "coalesce_frames", frames - f0, 2);
    chk(chars_seen - c0 == 128, "coalesce_chars", chars_seen - c0, 128);

    // Done held high for 5 cycles
    f0 = frames; hold = 5;
    pulse_refresh();
    wait_idle(4000);
    chk(frames - f0 == 1, "longdone_frames", frames - f0, 1);
    hold = 2;

    // Asynchronous reset mid-frame
    pulse_refresh();
    wait_idx(31, 1000);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midreset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    f0 = frames; c0 = chars_seen;
    wait_idle(2000);
    chk(frames - f0 == 1, "rst_frames", frames - f0, 1);
    chk(chars_seen - c0 == 64, "rst_chars", chars_seen - c0, 64);
    chk(frame_chars[5] == 7'h20, "rst_c5_blank", int'(frame_chars[5]), 'h20);

    // Random host traffic and controller timing
    for (int cyc = 0; cyc < 3000; cyc++) begin
      wr_en   = ($urandom % 8) == 0;
      wr_addr = 6'($urandom);
      wr_char = 7'($urandom_range(32, 126));
      refresh = ($urandom % 64) == 0;
      if (($urandom % 200) == 0) begin
        dly  = $urandom_range(0, 6);
        hold = $urandom_range(1, 4);
      end
      @(negedge clk);
    end
    wr_en = 1'b0; refresh = 1'b0;
    wait_idle(8000);
    chk(!o_busy, "final_idle", int'(o_busy), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
